// File: rtl/spi_slave_mw.sv
// Parametrised SPI slave: oversampled pins, word-wise rx strobe,
// software-loaded tx table driving MISO, frame bookkeeping.
module spi_slave_mw #(
    parameter int  DATA_W    = 8,
    parameter int  NUM_WORDS = 2,
    parameter bit  CPOL      = 1'b0,
    parameter bit  CPHA      = 1'b0,
    parameter bit  MSB_FIRST = 1'b1,
    localparam int AW        = $clog2(NUM_WORDS)
) (
    input  logic              clk100,
    input  logic              rstn,
    input  logic              sclk_i,
    input  logic              csn_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    input  logic              tx_wr_i,
    input  logic [AW-1:0]     tx_addr_i,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic [AW-1:0]     rx_idx_o,
    output logic              frame_active_o,
    output logic              frame_done_o,
    output logic [7:0]        frame_words_o
);

    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t            state;
    logic [2:0]        sclk_q;
    logic [2:0]        csn_q;
    logic [1:0]        mosi_q;
    logic [DATA_W-1:0] tx_tab [NUM_WORDS];
    logic [DATA_W-1:0] shift_rx;
    logic [DATA_W-1:0] shift_tx;
    logic [CW-1:0]     bit_cnt;
    logic [AW-1:0]     word_idx;
    logic [7:0]        run_cnt;

    logic              sclk_rise;
    logic              sclk_fall;
    logic              lead_edge;
    logic              trail_edge;
    logic              sample_edge;
    logic              shift_edge;
    logic              csn_fall;
    logic              csn_rise;
    logic              mosi_bit;
    logic              word_done;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] tx_shifted;

    // Two-flop synchronisers; sclk/csn get a third flop for edge detection.
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            sclk_q <= {3{CPOL}};
            csn_q  <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk_i};
            csn_q  <= {csn_q[1:0], csn_i};
            mosi_q <= {mosi_q[0], mosi_i};
        end
    end

    assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign csn_fall    = ~csn_q[1] & csn_q[2];
    assign csn_rise    = csn_q[1] & ~csn_q[2];
    assign mosi_bit    = mosi_q[1];
    assign word_done   = (bit_cnt == CW'(DATA_W - 1));

    assign rx_next = MSB_FIRST ? {shift_rx[DATA_W-2:0], mosi_bit}
                               : {mosi_bit, shift_rx[DATA_W-1:1]};

    assign tx_shifted = MSB_FIRST ? {shift_tx[DATA_W-2:0], 1'b0}
                                  : {1'b0, shift_tx[DATA_W-1:1]};

    // Transmit table: written any cycle, read when a word is loaded.
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                tx_tab[i] <= '0;
            end
        end else if (tx_wr_i) begin
            tx_tab[tx_addr_i] <= tx_data_i;
        end
    end

    // Frame state machine: CS edges frame the transfer, sclk edges shift.
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            shift_rx       <= '0;
            shift_tx       <= '0;
            bit_cnt        <= '0;
            word_idx       <= '0;
            run_cnt        <= '0;
            rx_data_o      <= '0;
            rx_valid_o     <= 1'b0;
            rx_idx_o       <= '0;
            frame_active_o <= 1'b0;
            miso_oe_o      <= 1'b0;
            frame_done_o   <= 1'b0;
            frame_words_o  <= '0;
        end else begin
            rx_valid_o   <= 1'b0;
            frame_done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (csn_fall) begin
                        state          <= ACTIVE;
                        bit_cnt        <= '0;
                        word_idx       <= '0;
                        run_cnt        <= '0;
                        shift_tx       <= tx_tab[0];
                        frame_active_o <= 1'b1;
                        miso_oe_o      <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (csn_rise) begin
                        // Partial word is dropped; CS beats any sclk edge.
                        state          <= IDLE;
                        frame_active_o <= 1'b0;
                        miso_oe_o      <= 1'b0;
                        frame_done_o   <= 1'b1;
                        frame_words_o  <= run_cnt;
                    end else begin
                        if (sample_edge) begin
                            shift_rx <= rx_next;
                            if (word_done) begin
                                bit_cnt    <= '0;
                                rx_data_o  <= rx_next;
                                rx_idx_o   <= word_idx;
                                rx_valid_o <= 1'b1;
                                word_idx   <= word_idx + AW'(1);
                                if (run_cnt != 8'hff) begin
                                    run_cnt <= run_cnt + 8'd1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                        // bit_cnt == 0 on a shift edge marks a word boundary.
                        if (shift_edge) begin
                            if (bit_cnt == '0) begin
                                shift_tx <= tx_tab[word_idx];
                            end else begin
                                shift_tx <= tx_shifted;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign miso_o = frame_active_o &
                    (MSB_FIRST ? shift_tx[DATA_W-1] : shift_tx[0]);

endmodule
